cnt_74x163_chain: RTL and testbench

- Cycle-accurate behavioural model of N cascaded 74x163 synchronous 4-bit binary counters. Each stage's ENT is chained to the previous stage's RCO, as on a board.
- Sits downstream of the mapped gate cells (OR/AND/NAND) that form its LOAD/ENP/ENT/CLR decode terminals.
- Consumes those cells' outputs and produces a wide count plus carry outputs for address generators and program counters built from 74xx parts.

---
 rtl/cnt_74x163_chain.sv | 46 ++++
 tb/tb_cnt_74x163_chain.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cnt_74x163_chain.sv
// STAGES cascaded 74x163 4-bit synchronous counters; Q updates on the sampling edge, carries are combinational.
// No backpressure: every control is sampled each rising CLK edge with priority RST > CLR > LOAD > count > hold.
module cnt_74x163_chain #(
    parameter int                  STAGES = 2,
    parameter logic [4*STAGES-1:0] INIT   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic                  ENP,
    input  logic                  ENT,
    input  logic [4*STAGES-1:0]   D,
    output logic [4*STAGES-1:0]   Q,
    output logic                  RCO,
    output logic [STAGES-1:0]     RCO_STAGE
);

    // ent_chain[i] is the ENT pin of stage i, wired from the previous RCO as on a board
    logic [STAGES:0] ent_chain;

    assign ent_chain[0] = ENT;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [3:0] q_r;

        always_ff @(posedge CLK) begin
            if (RST)
                q_r <= INIT[4*g +: 4];
            else if (CLR)
                q_r <= 4'h0;
            else if (LOAD)
                q_r <= D[4*g +: 4];
            else if (ENP && ent_chain[g])
                q_r <= q_r + 4'h1;
        end

        // ENP deliberately does not gate the carry, matching the 74x163
        assign RCO_STAGE[g]   = ent_chain[g] && (q_r == 4'hF);
        assign ent_chain[g+1] = RCO_STAGE[g];
        assign Q[4*g +: 4]    = q_r;
    end

    assign RCO = RCO_STAGE[STAGES-1];

endmodule

// File: tb/tb_cnt_74x163_chain.sv
// Scoreboarded bench: three counter chains (8-bit INIT=0, 8-bit INIT=0x33, 4-bit) share one stimulus stream.
module tb_cnt_74x163_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, load, enp, ent;
    logic [7:0] d;

    logic [7:0] q_a, q_b;
    logic [3:0] q_c;
    logic [1:0] rs_a, rs_b;
    logic [0:0] rs_c;
    logic       rco_a, rco_b, rco_c;

    cnt_74x163_chain #(.STAGES(2), .INIT(8'h00)) dut_a (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD(load), .ENP(enp), .ENT(ent),
        .D(d), .Q(q_a), .RCO(rco_a), .RCO_STAGE(rs_a)
    );

    cnt_74x163_chain #(.STAGES(2), .INIT(8'h33)) dut_b (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD(load), .ENP(enp), .ENT(ent),
        .D(d), .Q(q_b), .RCO(rco_b), .RCO_STAGE(rs_b)
    );

    cnt_74x163_chain #(.STAGES(1), .INIT(4'h0)) dut_c (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD(load), .ENP(enp), .ENT(ent),
        .D(d[3:0]), .Q(q_c), .RCO(rco_c), .RCO_STAGE(rs_c)
    );

    localparam int NI = 3;
    int stages_of [NI] = '{2, 2, 1};
    int init_of   [NI] = '{'h00, 'h33, 'h0};
    int mstate    [NI];

    typedef struct packed {
        logic [2:0][7:0] q;
        logic [2:0][1:0] rs;
        logic [2:0]      r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Stage i carries when ENT is high and the low 4*(i+1) bits of the count are all ones.
    function automatic int rco_bits(int q, int stages, bit t);
        int r = 0;
        for (int i = 0; i < stages; i++) begin
            int m = 1 << (4 * (i + 1));
            if (t && (q % m) == m - 1) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic step(input bit r, input bit c, input bit l, input bit p, input bit t,
                        input logic [7:0] dv);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; clr = c; load = l; enp = p; ent = t; d = dv;
        for (int k = 0; k < NI; k++) begin
            int w    = 1 << (4 * stages_of[k]);
            int bits = rco_bits(mstate[k], stages_of[k], t);
            e.q[k]  = 8'(mstate[k]);
            e.rs[k] = 2'(bits);
            e.r[k]  = ((bits >> (stages_of[k] - 1)) & 1) != 0;
            if (r)          mstate[k] = init_of[k] % w;
            else if (c)     mstate[k] = 0;
            else if (l)     mstate[k] = int'(dv) % w;
            else if (p && t) mstate[k] = (mstate[k] + 1) % w;
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, k, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("q",   0, q_a,                 mon_e.q[0]);
            chk("rcs", 0, {6'b0, rs_a},        {6'b0, mon_e.rs[0]});
            chk("rco", 0, {7'b0, rco_a},       {7'b0, mon_e.r[0]});
            chk("q",   1, q_b,                 mon_e.q[1]);
            chk("rcs", 1, {6'b0, rs_b},        {6'b0, mon_e.rs[1]});
            chk("rco", 1, {7'b0, rco_b},       {7'b0, mon_e.r[1]});
            chk("q",   2, {4'b0, q_c},         mon_e.q[2]);
            chk("rcs", 2, {7'b0, rs_c},        {6'b0, mon_e.rs[2]});
            chk("rco", 2, {7'b0, rco_c},       {7'b0, mon_e.r[2]});
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; enp = 1'b0; ent = 1'b0; d = 8'h00;
        repeat (2) @(posedge clk);
        for (int k = 0; k < NI; k++) mstate[k] = init_of[k] % (1 << (4 * stages_of[k]));

        // reset state seen with ENT both low and high
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        repeat (20) step(0, 0, 0, 1, 1, 8'h00);

        // load FE, count through FF and wrap
        step(0, 0, 1, 0, 0, 8'hFE);
        repeat (3) step(0, 0, 0, 1, 1, 8'h00);

        // carry into stage 1, then ENT=0 holds at 0F
        step(0, 0, 1, 0, 1, 8'h0F);
        step(0, 0, 0, 1, 1, 8'h00);
        step(0, 0, 0, 1, 1, 8'h00);
        step(0, 0, 1, 0, 0, 8'h0F);
        repeat (3) step(0, 0, 0, 1, 0, 8'h00);

        // ENP=0 at FF keeps RCO high; dropping ENT kills it
        step(0, 0, 1, 0, 1, 8'hFF);
        repeat (3) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, 8'h00);

        // priority: CLR over LOAD, LOAD over count, RST over everything
        step(0, 1, 1, 1, 1, 8'h5A);
        step(0, 0, 1, 1, 1, 8'h5A);
        step(1, 1, 1, 1, 1, 8'hA5);
        step(1, 0, 0, 1, 1, 8'h00);
        step(1, 0, 0, 1, 1, 8'h00);
        step(0, 0, 0, 1, 1, 8'h00);

        // full wrap of the 4-bit chain
        step(0, 1, 0, 0, 0, 8'h00);
        repeat (18) step(0, 0, 0, 1, 1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(31) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                 $urandom_range(3) != 0, $urandom_range(3) != 0, 8'($urandom));
        end
        step(0, 0, 0, 0, 1, 8'h00);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
